iterative_mul_unit: RTL and testbench
=====================================

# iterative_mul_unit

Iterative shift-add multiply execute pipe implementing RV32M MUL/MULH/MULHSU/MULHU. It sits between decode/issue and the writeback-commit unit. It accepts one operation from the D__X side and produces one X__W message carrying the original pc and seq_num, so the downstream reordering writeback-commit unit can retire it out of order. It is a single-entry, non-pipelined unit that holds one operation in flight at a time.

## Interface
- p_seq_num_bits, 5, width of the in-flight sequence number
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- D_val  input  1  operation valid from issue
- D_rdy  output  1  unit can accept an operation
- D_pc  input  32  instruction pc
- D_seq_num  input  p_seq_num_bits  instruction sequence number
- D_op1, D_op2  input  32  rs1 / rs2 operand values
- D_waddr  input  5  destination register
- D_wen  input  1  destination write enable
- D_uop  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- W_val  output  1  X__W message valid
- W_rdy  input  1  writeback-commit unit accepts
- W_pc, W_seq_num, W_waddr, W_wen  output  32/p_seq_num_bits/5/1  latched from the D side
- W_wdata  output  32  result
- function trace(): string  linetrace; shows state and, when W_val is high, the seq_num and wdata

## Operation
- FSM states are IDLE, CALC and DONE. Reset state is IDLE.
- D_rdy = (state == IDLE). W_val = (state == DONE). Both are decoded from the state register with no combinational path from D_val or W_rdy.
- **IDLE:** on D_val, latch pc, seq_num, waddr, wen and uop, then go to CALC.
- **Sign handling at accept:**
  - op1 is treated as signed for MULH and MULHSU.
  - op2 is treated as signed for MULH only.
  - Load mcand (64 bit) = |op1| zero-extended and mplier (32 bit) = |op2|.
  - neg = sign(op1) XOR sign(op2), counting only the operands treated as signed.
  - Clear acc (64 bit) and cnt (5 bit).
- **CALC, one step per cycle:**
  - If mplier[0], acc += mcand (modulo 2^64).
  - Then mcand <<= 1, mplier >>= 1, cnt += 1.
  - When the step with cnt == 31 completes, go to DONE.
- **Entering DONE:**
  - Form prod = neg ? (~acc + 1) : acc, in 64 bits.
  - W_wdata = prod[31:0] for MUL, otherwise prod[63:32]. It is registered.
- **DONE:** all W_* outputs hold stable while W_rdy is 0. When W_rdy is 1, go to IDLE.
- **Boundary cases:**
  - |0x80000000| is 0x80000000, handled as unsigned 32-bit magnitude.
  - MUL ignores signedness: any uop yields the same low word.
- **Reset mid-operation:** the in-flight op is discarded and no X__W message is produced. Outputs take their reset values:
  - W_val 0
  - D_rdy 1
  - W_pc, W_seq_num, W_waddr, W_wdata and W_wen all 0

## Timing
- Accept in cycle N (D_val && D_rdy). CALC runs in cycles N+1..N+32. W_val first rises in cycle N+33.
- The handoff completes in the cycle where W_val && W_rdy. D_rdy rises the following cycle; there is no same-cycle accept while in DONE.
- Minimum initiation interval is 34 cycles with W_rdy tied high.
- D_* inputs are sampled only in the accept cycle. Later changes are ignored.

## Configuration
- Macro: ITERATIVE_MUL_EARLY_TERM_EN.
- **Defined:** in CALC, also go to DONE after any step whose post-shift mplier is 0.
  - Latency from accept to W_val becomes k+1 cycles, where k = max(1, bit index of the MSB of |op2| + 1).
  - Examples: op2 = 0 or 1 gives W_val in N+2. op2 = 0xFFFFFFFF with MULHU gives N+33.
  - Results are identical to the undefined case.
- **Undefined:** fixed 32 CALC cycles. cnt is the only termination condition.

## Test plan
- **Basic MUL timing:** MUL op1=3, op2=4, seq_num=2, waddr=5, W_rdy=1 -> one X__W message with wdata=12, seq_num=2, waddr=5, wen=1 and pc preserved. W_val rises exactly 33 cycles after accept (macro undefined).
- **Signed extremes:** MULH 0x80000000 x 0x80000000 -> wdata 0x40000000. MUL with the same operands -> 0x00000000.
- **Mixed signedness:** MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- **Backpressure:** hold W_rdy=0 for 5 cycles in DONE -> W_* are constant, D_rdy=0, and a D_val offered meanwhile is not accepted. It is accepted the cycle after the handoff.
- **Reset mid-operation:** drive rst=0 at cycle 10 of CALC -> W_val=0 and D_rdy=1 immediately, and no message is emitted. A following MUL 7 x 6 yields 42.
- **Early termination (macro defined):** MUL 9 x 1 -> wdata 9, W_val in N+2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> W_val in N+33.

Source files
------------

// File: rtl/iterative_mul_unit.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one op in flight.
// Optional early termination when the remaining multiplier is zero: ITERATIVE_MUL_EARLY_TERM_EN.
module iterative_mul_unit #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      D_val,
  output logic                      D_rdy,
  input  logic [31:0]               D_pc,
  input  logic [p_seq_num_bits-1:0] D_seq_num,
  input  logic [31:0]               D_op1,
  input  logic [31:0]               D_op2,
  input  logic [4:0]                D_waddr,
  input  logic                      D_wen,
  input  logic [1:0]                D_uop,
  output logic                      W_val,
  input  logic                      W_rdy,
  output logic [31:0]               W_pc,
  output logic [p_seq_num_bits-1:0] W_seq_num,
  output logic [4:0]                W_waddr,
  output logic                      W_wen,
  output logic [31:0]               W_wdata,
  output logic [1:0]                dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid
  // and ready are both decoded from the state register only.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [63:0]   mcand_q, acc_q, acc_step, prod;
  logic [31:0]   mplier_q, mplier_step, op1_mag, op2_mag;
  logic [4:0]    cnt_q;
  logic [1:0]    uop_q;
  logic          neg_q, op1_neg, op2_neg, calc_last;

  always_comb begin
    op1_neg     = D_op1[31] & ((D_uop == 2'b01) | (D_uop == 2'b10));
    op2_neg     = D_op2[31] & (D_uop == 2'b01);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    op1_mag     = op1_neg ? (~D_op1 + 32'd1) : D_op1;
    op2_mag     = op2_neg ? (~D_op2 + 32'd1) : D_op2;
    acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_step = mplier_q >> 1;
    prod        = neg_q ? (~acc_step + 64'd1) : acc_step;
`ifdef ITERATIVE_MUL_EARLY_TERM_EN
    calc_last   = (cnt_q == 5'd31) || (mplier_step == 32'd0);
`else
    calc_last   = (cnt_q == 5'd31);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (D_val)     state_d = CALC;
      CALC:    if (calc_last) state_d = DONE;
      DONE:    if (W_rdy)     state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign D_rdy     = (state_q == IDLE);
  assign W_val     = (state_q == DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      W_pc      <= '0;
      W_seq_num <= '0;
      W_waddr   <= '0;
      W_wen     <= 1'b0;
      W_wdata   <= '0;
      uop_q     <= '0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (D_val) begin
          W_pc      <= D_pc;
          W_seq_num <= D_seq_num;
          W_waddr   <= D_waddr;
          W_wen     <= D_wen;
          uop_q     <= D_uop;
          neg_q     <= op1_neg ^ op2_neg;
          mcand_q   <= {32'd0, op1_mag};
          mplier_q  <= op2_mag;
          acc_q     <= '0;
          cnt_q     <= '0;
        end
        CALC: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_step;
          cnt_q    <= cnt_q + 5'd1;
          // Result is taken from this step's sum so it is valid on DONE entry.
          if (calc_last) W_wdata <= (uop_q == 2'b00) ? prod[31:0] : prod[63:32];
        end
        default: ;
      endcase
    end
  end

  function automatic string trace();
    if (state_q == DONE)
      return $sformatf("%s seq=%0d wdata=%08h", state_q.name(), W_seq_num, W_wdata);
    return $sformatf("%s", state_q.name());
  endfunction

endmodule

// File: tb/tb_iterative_mul_unit.sv
// Randomized bench for iterative_mul_unit against an arithmetic reference model;
// latency expectations follow ITERATIVE_MUL_EARLY_TERM_EN when defined.
module tb_iterative_mul_unit;

  logic        clk, rst;
  logic        D_val, D_rdy, D_wen, W_val, W_rdy, W_wen;
  logic [31:0] D_pc, D_op1, D_op2, W_pc, W_wdata;
  logic [4:0]  D_seq_num, W_seq_num, D_waddr, W_waddr;
  logic [1:0]  D_uop, dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  iterative_mul_unit #(.p_seq_num_bits(5)) dut (
    .clk(clk), .rst(rst),
    .D_val(D_val), .D_rdy(D_rdy), .D_pc(D_pc), .D_seq_num(D_seq_num),
    .D_op1(D_op1), .D_op2(D_op2), .D_waddr(D_waddr), .D_wen(D_wen), .D_uop(D_uop),
    .W_val(W_val), .W_rdy(W_rdy), .W_pc(W_pc), .W_seq_num(W_seq_num),
    .W_waddr(W_waddr), .W_wen(W_wen), .W_wdata(W_wdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: full product of the operands as the ISA defines them
  function automatic logic [31:0] ref_mul(input logic [1:0] uop, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (uop == 2'b01 || uop == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (uop == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (uop == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_lat(input logic [1:0] uop, input logic [31:0] b);
`ifdef ITERATIVE_MUL_EARLY_TERM_EN
    logic [31:0] m;
    int k;
    m = (uop == 2'b01 && b[31]) ? (32'd0 - b) : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return k + 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // driver: one full transaction, including optional W-side stall
  task automatic run_op_full(input logic [1:0] uop, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] seq, input logic [4:0] wa, input logic wen,
                             input int stall);
    logic [31:0] pc, exp_w;
    int lat, guard, exp_lat;
    pc = $urandom;
    guard = 0;
    while (!D_rdy && guard < 100) begin @(negedge clk); guard++; end
    check("d_rdy_before_accept", D_rdy, 1);
    D_val = 1'b1; D_uop = uop; D_op1 = a; D_op2 = b;
    D_seq_num = seq; D_waddr = wa; D_wen = wen; D_pc = pc;
    W_rdy = (stall == 0);
    exp_q.push_back(ref_mul(uop, a, b));
    exp_lat = ref_lat(uop, b);
    @(posedge clk); #1;
    D_val = 1'b0; D_uop = 2'($urandom); D_op1 = $urandom; D_op2 = $urandom;
    D_seq_num = 5'($urandom); D_waddr = 5'($urandom); D_wen = 1'($urandom); D_pc = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!W_val && lat < 100);
    check("latency", 64'(lat), 64'(exp_lat));
    check("d_rdy_in_done", D_rdy, 0);
    exp_w = exp_q.pop_front();
    check("wdata", W_wdata, exp_w);
    check("pc", W_pc, pc);
    check("seq_num", W_seq_num, seq);
    check("waddr", W_waddr, wa);
    check("wen", W_wen, wen);
    if (stall > 0) begin
      D_val = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        check("hold_wval", W_val, 1);
        check("hold_drdy", D_rdy, 0);
        check("hold_wdata", W_wdata, exp_w);
        check("hold_pc", W_pc, pc);
        check("hold_seq_num", W_seq_num, seq);
      end
      D_val = 1'b0;
      W_rdy = 1'b1;
    end
    @(negedge clk);
    check("post_wval", W_val, 0);
    check("post_drdy", D_rdy, 1);
  endtask

  task automatic run_op(input logic [1:0] uop, input logic [31:0] a, input logic [31:0] b, input int stall);
    run_op_full(uop, a, b, 5'($urandom), 5'($urandom), 1'($urandom), stall);
  endtask

  initial begin
    int seen;
    rst = 1'b0; D_val = 1'b0; W_rdy = 1'b1;
    D_pc = '0; D_seq_num = '0; D_op1 = '0; D_op2 = '0; D_waddr = '0; D_wen = 1'b0; D_uop = '0;
    repeat (3) @(negedge clk);
    check("rst_wval", W_val, 0);
    check("rst_drdy", D_rdy, 1);
    check("rst_wdata", W_wdata, 0);
    check("rst_pc", W_pc, 0);
    check("rst_seq_num", W_seq_num, 0);
    check("rst_waddr", W_waddr, 0);
    check("rst_wen", W_wen, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op_full(2'b00, 32'd3, 32'd4, 5'd2, 5'd5, 1'b1, 0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'd9, 32'd1, 0);
    run_op(2'b11, 32'd5, 32'd0, 0);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd6, 5);

    // reset in the middle of CALC discards the op
    @(negedge clk);
    D_val = 1'b1; D_uop = 2'b11; D_op1 = 32'd5; D_op2 = 32'hFFFF_FFFF;
    D_pc = 32'h1234; D_seq_num = 5'd9; D_waddr = 5'd3; D_wen = 1'b1;
    @(posedge clk); #1;
    D_val = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_wval", W_val, 0);
    check("midrst_drdy", D_rdy, 1);
    check("midrst_pc", W_pc, 0);
    check("midrst_wdata", W_wdata, 0);
    check("midrst_wen", W_wen, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (W_val) seen = 1; end
    check("midrst_no_msg", 64'(seen), 0);
    run_op(2'b00, 32'd7, 32'd6, 0);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), $urandom_range(0, 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
